// File: rtl/aes_block_sequencer.sv
// Streams block_count plaintext/key pairs from a source memory through an AES core
// and writes each result to a destination memory, with timeout and completion status.
module aes_block_sequencer #(
    parameter int TEXT_WIDTH = 128,
    parameter int KEY_WIDTH  = 128,
    parameter int ADDR_WIDTH = 6,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   block_count_i,
    input  logic                  key_shared_i,
    output logic [ADDR_WIDTH-1:0] src_addr_o,
    input  logic [TEXT_WIDTH-1:0] src_text_i,
    input  logic [KEY_WIDTH-1:0]  src_key_i,
    output logic                  core_start_o,
    output logic [TEXT_WIDTH-1:0] core_text_o,
    output logic [KEY_WIDTH-1:0]  core_key_o,
    input  logic                  core_done_i,
    input  logic [TEXT_WIDTH-1:0] core_text_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [TEXT_WIDTH-1:0] wr_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH:0]   blocks_done_o
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  shared_q, shared_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [TEXT_WIDTH-1:0] text_q, text_d;
    logic [KEY_WIDTH-1:0]  key_q, key_d;
    logic [TEXT_WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]         blocks_q, blocks_d;
    logic                  error_q, error_d;
    logic [CW-1:0]         count_clamped;

    // Counts beyond the addressable range would revisit indices, so cap them.
    assign count_clamped = (block_count_i > MAX_COUNT) ? MAX_COUNT : block_count_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            count_q  <= '0;
            shared_q <= 1'b0;
            timer_q  <= '0;
            text_q   <= '0;
            key_q    <= '0;
            result_q <= '0;
            blocks_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            shared_q <= shared_d;
            timer_q  <= timer_d;
            text_q   <= text_d;
            key_q    <= key_d;
            result_q <= result_d;
            blocks_q <= blocks_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        shared_d = shared_q;
        timer_d  = timer_q;
        text_d   = text_q;
        key_d    = key_q;
        result_d = result_q;
        blocks_d = blocks_q;
        error_d  = error_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    count_d  = count_clamped;
                    shared_d = key_shared_i;
                    idx_d    = '0;
                    blocks_d = '0;
                    error_d  = 1'b0;
                    state_d  = (count_clamped == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                text_d = src_text_i;
                // In shared-key mode only index 0 supplies the key.
                if (!(shared_q && idx_q != '0)) key_d = src_key_i;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over a timeout landing on the same cycle
                if (core_done_i) begin
                    result_d = core_text_i;
                    state_d  = S_WRITE;
                end else if (timer_q == TIMER_LAST) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WRITE: begin
                blocks_d = blocks_q + CW'(1);
                if ({1'b0, idx_q} == count_q - CW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign src_addr_o    = idx_q;
    assign core_start_o  = (state_q == S_ISSUE);
    assign core_text_o   = text_q;
    assign core_key_o    = key_q;
    assign wr_en_o       = (state_q == S_WRITE);
    assign wr_addr_o     = idx_q;
    assign wr_data_o     = result_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign error_o       = error_q;
    assign blocks_done_o = blocks_q;
endmodule

// File: tb/tb_aes_block_sequencer.sv
// Scoreboard bench for aes_block_sequencer: a behavioural core with fixed latency,
// expected issues/writes queued by the stimulus and popped by negedge monitors.
module tb_aes_block_sequencer;
    localparam int TW = 128, KW = 128, AW = 6, TO = 64, LAT = 11;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0, rst_n = 1'b1;
    logic          start = 1'b0, key_shared = 1'b0;
    logic [AW:0]   block_count = '0;
    logic [AW-1:0] src_addr, wr_addr;
    logic [TW-1:0] src_text, core_text, core_res = '0, wr_data;
    logic [KW-1:0] src_key, core_key;
    logic          core_start, core_done = 1'b0, wr_en, busy, done, error;
    logic [AW:0]   blocks_done;

    logic [TW-1:0] mem_text [64];
    logic [KW-1:0] mem_key  [64];
    assign src_text = mem_text[src_addr];
    assign src_key  = mem_key[src_addr];

    aes_block_sequencer #(.TEXT_WIDTH(TW), .KEY_WIDTH(KW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .block_count_i(block_count),
        .key_shared_i(key_shared), .src_addr_o(src_addr), .src_text_i(src_text),
        .src_key_i(src_key), .core_start_o(core_start), .core_text_o(core_text),
        .core_key_o(core_key), .core_done_i(core_done), .core_text_i(core_res),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy),
        .done_o(done), .error_o(error), .blocks_done_o(blocks_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [TW-1:0] text; logic [KW-1:0] key; } iss_t;
    typedef struct { logic [AW-1:0] addr; logic [TW-1:0] data; } wr_t;
    iss_t exp_iss[$];
    wr_t  exp_wr[$];

    int checks = 0, passed = 0;
    int cyc = 0, last_iss_cyc = -1, last_wr_cyc = -1, start_cyc = 0;
    bit hang = 1'b0, early = 1'b0, hold = 1'b0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Stand-in core: the known FIPS-197 vector, otherwise a cheap mix of text and key.
    function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k);
        if (t == PT && k == KEY0) return CT;
        return t ^ {k[63:0], k[127:64]};
    endfunction

    always @(posedge clk) cyc++;

    // Core model: done is high for the cycle LAT after the start pulse.
    int lat_cnt = 0;
    logic [TW-1:0] pend;
    always @(negedge clk) begin
        core_done = 1'b0;
        if (!rst_n) lat_cnt = 0;
        if (early && core_start) begin
            core_done = 1'b1;
            core_res  = 128'hdead_beef;
        end
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0 && !hang) begin
                core_done = 1'b1;
                core_res  = pend;
            end
        end
        if (rst_n && core_start) begin
            lat_cnt = LAT;
            pend    = core_fn(core_text, core_key);
        end
    end

    // Monitors: pop the expected issue/write whenever the DUT presents one.
    always @(negedge clk) begin : mon
        iss_t ie;
        wr_t  we;
        if (core_start) begin
            last_iss_cyc = cyc;
            if (exp_iss.size() == 0) chk("unexpected_issue", 1, 0);
            else begin
                ie = exp_iss.pop_front();
                chk("issue_text", core_text, ie.text);
                chk("issue_key", core_key, ie.key);
            end
        end
        if (wr_en) begin
            if (last_wr_cyc >= 0) chk("wr_spacing", 128'(cyc - last_wr_cyc), 14);
            last_wr_cyc = cyc;
            if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                we = exp_wr.pop_front();
                chk("wr_addr", wr_addr, we.addr);
                chk("wr_data", wr_data, we.data);
            end
        end
    end

    task automatic push_run(input int n, input bit shared);
        int eff;
        iss_t ie;
        wr_t  we;
        eff = (n > 64) ? 64 : n;
        for (int i = 0; i < eff; i++) begin
            ie.text = mem_text[i];
            ie.key  = shared ? mem_key[0] : mem_key[i];
            we.addr = i[AW-1:0];
            we.data = core_fn(ie.text, ie.key);
            exp_iss.push_back(ie);
            exp_wr.push_back(we);
        end
    endtask

    task automatic start_run(input int n, input bit shared);
        @(negedge clk);
        block_count = n[AW:0];
        key_shared  = shared;
        start       = 1'b1;
        last_wr_cyc = -1;
        start_cyc   = cyc;
    endtask

    task automatic wait_done(input int limit, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (done) begin
                dcyc  = cyc;
                start = 1'b0;
                break;
            end
        end
        chk("done_seen", 128'(dcyc >= 0), 1);
    endtask

    task automatic chk_empty(input string name);
        chk({name, "_iss_left"}, exp_iss.size(), 0);
        chk({name, "_wr_left"}, exp_wr.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d, erise, dat;
        iss_t ie;
        wr_t  we;
        for (int i = 0; i < 64; i++) begin
            mem_text[i] = {4{32'h1111_1111 * (i + 1)}};
            mem_key[i]  = {4{32'h0f0f_0000 + i}};
        end
        mem_text[0] = PT;
        mem_key[0]  = KEY0;

        #1 rst_n = 1'b0;
        #20;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_blocks", blocks_done, 0);
        chk("rst_strobes", {core_start, wr_en}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Single block on the FIPS-197 vector.
        ie.text = PT; ie.key = KEY0; exp_iss.push_back(ie);
        we.addr = '0; we.data = CT;  exp_wr.push_back(we);
        start_run(1, 1'b0);
        wait_done(100, d);
        chk("t1_done_after_wr", 128'(d - last_wr_cyc), 1);
        chk("t1_blocks", blocks_done, 1);
        chk("t1_error", error, 0);
        @(negedge clk);
        chk("t1_done_pulse", {done, busy}, 0);
        chk_empty("t1");

        // Shared key: every issue must carry key[0].
        push_run(4, 1'b1);
        start_run(4, 1'b1);
        wait_done(200, d);
        chk("t2_blocks", blocks_done, 4);
        chk_empty("t2");

        // Zero count goes straight to DONE in the cycle after start is sampled.
        start_run(0, 1'b0);
        wait_done(20, d);
        chk("t3_done_cyc", 128'(d - start_cyc), 1);
        chk("t3_blocks", blocks_done, 0);
        chk_empty("t3");

        // Hung core: error after 64 WAIT cycles, i.e. visible 65 cycles after the issue cycle.
        hang = 1'b1;
        ie.text = mem_text[0]; ie.key = mem_key[0]; exp_iss.push_back(ie);
        start_run(3, 1'b0);
        erise = -1; dat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (error) begin
                erise = cyc;
                dat   = done;
                break;
            end
        end
        chk("t4_err_rise", 128'(erise - last_iss_cyc), 65);
        chk("t4_done_with_err", 128'(dat), 1);
        chk("t4_blocks", blocks_done, 0);
        chk_empty("t4");
        hang = 1'b0;
        repeat (3) @(negedge clk);
        push_run(1, 1'b0);
        start_run(1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("t4_err_cleared", error, 0);
        wait_done(100, d);
        chk("t4_rerun_blocks", blocks_done, 1);
        chk_empty("t4b");

        // Reset during WAIT of the second block.
        for (int i = 0; i < 2; i++) begin
            ie.text = mem_text[i]; ie.key = mem_key[i]; exp_iss.push_back(ie);
        end
        we.addr = '0; we.data = core_fn(mem_text[0], mem_key[0]); exp_wr.push_back(we);
        start_run(4, 1'b0);
        for (int i = 0; i < 100 && exp_iss.size() != 0; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_addr", src_addr, 0);
        chk("t5_async_blocks", blocks_done, 0);
        chk("t5_async_strobes", {core_start, wr_en, done}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk_empty("t5");
        push_run(1, 1'b0);
        start_run(1, 1'b0);
        wait_done(100, d);
        chk("t5_restart_blocks", blocks_done, 1);
        chk_empty("t5b");

        // start held through a run, plus a spurious done during ISSUE.
        hold = 1'b1; early = 1'b1;
        push_run(2, 1'b0);
        start_run(2, 1'b0);
        wait_done(200, d);
        hold = 1'b0; early = 1'b0;
        chk("t6_blocks", blocks_done, 2);
        repeat (4) @(negedge clk);
        chk("t6_no_restart", busy, 0);
        chk_empty("t6");

        // Over-range count clamps to 64 blocks covering every index.
        push_run(127, 1'b0);
        start_run(127, 1'b0);
        wait_done(64 * 14 + 50, d);
        chk("t7_blocks", blocks_done, 64);
        chk_empty("t7");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
